// File: rtl/bsg_fifo_rr_drain_sched_pkg.sv
// Width helpers shared by the drain scheduler, its interface and its picker.
package bsg_fifo_rr_drain_sched_pkg;

  // Bits needed to name one of n sources (at least one bit).
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold a burst count in the range 0..b.
  function automatic int cnt_width(input int b);
    return (b < 1) ? 1 : $clog2(b + 1);
  endfunction

endpackage

// File: rtl/bsg_fifo_rr_drain_sched_if.sv
// Bundle of the upstream FIFO valid/yumi bank and the downstream valid/ready port.
// Handshake: upstream v_i[i] is a FIFO valid that stays up until yumi_o[i] is pulsed;
// downstream a beat moves on any cycle where v_o & ready_i, and v_o never looks at ready_i.
interface bsg_fifo_rr_drain_sched_if
  import bsg_fifo_rr_drain_sched_pkg::*;
#(
  parameter int num_fifos_p = 4,
  parameter int width_p     = 32,
  parameter int burst_max_p = 4
);
  localparam int id_w_lp  = id_width(num_fifos_p);
  localparam int cnt_w_lp = cnt_width(burst_max_p);

  logic [num_fifos_p-1:0]         v_i;
  logic [num_fifos_p*width_p-1:0] data_i;
  logic [num_fifos_p-1:0]         yumi_o;
  logic                           v_o;
  logic [width_p-1:0]             data_o;
  logic [id_w_lp-1:0]             id_o;
  logic                           ready_i;

  // Internal state made visible for checkers.
  logic [id_w_lp-1:0]             dbg_last_o;
  logic [cnt_w_lp-1:0]            dbg_burst_cnt_o;
  logic                           dbg_hold_v_o;

  modport slave (
    input  v_i, data_i, ready_i,
    output yumi_o, v_o, data_o, id_o, dbg_last_o, dbg_burst_cnt_o, dbg_hold_v_o
  );

  modport master (
    output v_i, data_i, ready_i,
    input  yumi_o, v_o, data_o, id_o, dbg_last_o, dbg_burst_cnt_o, dbg_hold_v_o
  );
endinterface

// File: rtl/bsg_rr_pick.sv
// Combinational round-robin scan: first set request after start_i, wrapping to start_i last.
module bsg_rr_pick
  import bsg_fifo_rr_drain_sched_pkg::*;
#(
  parameter int num_p = 4,
  localparam int id_w_lp = id_width(num_p)
) (
  input  logic [num_p-1:0]   req_i,
  input  logic [id_w_lp-1:0] start_i,
  output logic               v_o,
  output logic [id_w_lp-1:0] id_o
);

  // Walk offsets from farthest to nearest so the nearest requester is assigned last and wins.
  always_comb begin
    int idx;
    v_o  = 1'b0;
    id_o = '0;
    idx  = 0;
    for (int off = num_p; off >= 1; off--) begin
      idx = int'(start_i) + off;
      if (idx >= num_p) idx = idx - num_p;
      if (req_i[idx[id_w_lp-1:0]]) begin
        v_o  = 1'b1;
        id_o = idx[id_w_lp-1:0];
      end
    end
  end

endmodule

// File: rtl/bsg_fifo_rr_drain_sched.sv
// Drains a bank of valid/yumi FIFOs into one valid/ready consumer with
// burst-limited round-robin arbitration and a stall hold that freezes the grant.
module bsg_fifo_rr_drain_sched
  import bsg_fifo_rr_drain_sched_pkg::*;
#(
  parameter int num_fifos_p = 4,
  parameter int width_p     = 32,
  parameter int burst_max_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  bsg_fifo_rr_drain_sched_if.slave bus
);
  localparam int id_w_lp  = id_width(num_fifos_p);
  localparam int cnt_w_lp = cnt_width(burst_max_p);
  localparam logic [cnt_w_lp-1:0] burst_max_lp = cnt_w_lp'(burst_max_p);
  localparam logic [id_w_lp-1:0]  last_rst_lp  = id_w_lp'(num_fifos_p - 1);

  if (num_fifos_p < 2) begin : g_bad_num
    $error("bsg_fifo_rr_drain_sched: num_fifos_p must be >= 2");
  end
  if (burst_max_p < 1) begin : g_bad_burst
    $error("bsg_fifo_rr_drain_sched: burst_max_p must be >= 1");
  end

  logic [id_w_lp-1:0]  last_q, last_d;
  logic [cnt_w_lp-1:0] burst_cnt_q, burst_cnt_d;
  logic                hold_v_q, hold_v_d;
  logic [id_w_lp-1:0]  hold_id_q, hold_id_d;

  logic                rr_v;
  logic [id_w_lp-1:0]  rr_id;
  logic                sticky;
  logic                any_v;
  logic [id_w_lp-1:0]  grant;
  logic                v_lo;
  logic                xfer;
  logic [num_fifos_p-1:0] yumi_lo;
  logic [width_p-1:0]  data_lo;

  bsg_rr_pick #(.num_p(num_fifos_p)) pick (
    .req_i   (bus.v_i),
    .start_i (last_q),
    .v_o     (rr_v),
    .id_o    (rr_id)
  );

  // A zero count means nobody owns the link yet (post-reset), so the scan starts at source 0.
  assign sticky = bus.v_i[last_q] && (burst_cnt_q != '0) && (burst_cnt_q < burst_max_lp);

  // Grant selection: a held beat wins, then the sticky owner, then the round-robin scan.
  always_comb begin
    grant = rr_id;
    any_v = rr_v;
    if (hold_v_q) begin
      grant = hold_id_q;
      any_v = bus.v_i[hold_id_q];
    end else if (sticky) begin
      grant = last_q;
      any_v = 1'b1;
    end
  end

  assign v_lo = any_v & ~reset_i;
  assign xfer = v_lo & bus.ready_i;

  // Output decode: data mux on the grant and a yumi only to the accepted source.
  always_comb begin
    yumi_lo = '0;
    data_lo = '0;
    for (int i = 0; i < num_fifos_p; i++) begin
      if (grant == id_w_lp'(i)) begin
        data_lo    = bus.data_i[i*width_p +: width_p];
        yumi_lo[i] = xfer;
      end
    end
  end

  assign bus.v_o             = v_lo;
  assign bus.data_o          = data_lo;
  assign bus.id_o            = grant;
  assign bus.yumi_o          = yumi_lo;
  assign bus.dbg_last_o      = last_q;
  assign bus.dbg_burst_cnt_o = burst_cnt_q;
  assign bus.dbg_hold_v_o    = hold_v_q;

  // Next state: accepted beats advance ownership and burst count; stalled beats latch the grant.
  always_comb begin
    last_d      = last_q;
    burst_cnt_d = burst_cnt_q;
    hold_v_d    = hold_v_q;
    hold_id_d   = hold_id_q;
    if (xfer) begin
      hold_v_d = 1'b0;
      last_d   = grant;
      if ((grant == last_q) && (burst_cnt_q < burst_max_lp)) begin
        burst_cnt_d = burst_cnt_q + cnt_w_lp'(1);
      end else begin
        burst_cnt_d = cnt_w_lp'(1);
      end
    end else if (v_lo) begin
      hold_v_d  = 1'b1;
      hold_id_d = grant;
    end
  end

  // State registers with asynchronous reset; reset drops any held beat.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_q      <= last_rst_lp;
      burst_cnt_q <= '0;
      hold_v_q    <= 1'b0;
      hold_id_q   <= '0;
    end else begin
      last_q      <= last_d;
      burst_cnt_q <= burst_cnt_d;
      hold_v_q    <= hold_v_d;
      hold_id_q   <= hold_id_d;
    end
  end

  a_yumi_onehot0 : assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(yumi_lo))
    else $error("yumi_o has more than one bit set");
  a_hold_valid : assert property (@(posedge clk_i) disable iff (reset_i) hold_v_q |-> bus.v_i[hold_id_q])
    else $error("held source dropped its valid before yumi");

endmodule
